// File: rtl/div_defs.sv
// Shared definitions for the sequential divider:
// FSM state encodings and the default operand width.
package div_defs;

  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_div4_rcs.sv
// Ripple-borrow subtractor built from full-adder cells
// as a + ~b + 1; borrow is the inverted carry out.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // single-bit full adder
  always_comb begin
    s  = a ^ b ^ ci;
    co = (a & b) | (ci & (a ^ b));
  end

endmodule

module rcs #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_bit
    fa u_fa (
      .a  (a[i]),
      .b  (~b[i]),
      .ci (c[i]),
      .s  (diff[i]),
      .co (c[i+1])
    );
  end

  assign borrow = ~c[W];

endmodule

// File: rtl/seq_div4.sv
// Multi-cycle restoring divider, one quotient bit
// per clock, with start/busy/done handshake.
module seq_div4
  import div_defs::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         dz
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  dvd_q, dvd_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic          dz_q, dz_d;

  logic [N:0]    t;
  logic [N:0]    diff;
  logic          borrow;
  logic          keep;

  assign t = {rem_q, dvd_q[cnt_q]};

  rcs #(.W(N + 1)) u_rcs (
    .a      (t),
    .b      ({1'b0, dvs_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  // diff[N] can only be set when the subtract borrowed
  assign keep = borrow | diff[N];

  // next-state, datapath and result update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (b == '0) begin
            state_d = DONE;
            q_d     = '1;
            r_d     = a;
            dz_d    = 1'b1;
          end else begin
            state_d = BUSY;
            dvd_d   = a;
            dvs_d   = b;
            rem_d   = '0;
            cnt_d   = CW'(N - 1);
            q_d     = '0;
            r_d     = '0;
            dz_d    = 1'b0;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        rem_d       = keep ? t[N-1:0] : diff[N-1:0];
        q_d[cnt_q]  = ~keep;
        if (cnt_q == '0) begin
          state_d = DONE;
          r_d     = rem_d;
          dz_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = (state_q == BUSY);
  assign done = (state_q == DONE);
  assign q    = q_q;
  assign r    = r_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_seq_div4.sv
// Bench for seq_div4: vector table, scoreboard
// queue and hand-written handshake corner cases.
module tb_seq_div4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [3:0] q;
  logic [3:0] r;
  logic       dz;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } vec_t;

  exp_t sb[$];
  exp_t last;

  seq_div4 dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dz    (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] eq,
                      input logic [3:0] er,
                      input logic       edz);
    exp_t e;
    e.q  = eq;
    e.r  = er;
    e.dz = edz;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string nm);
    if (sb.size() == 0) begin
      chk({nm, " unexpected done"}, 1, 0);
    end else begin
      last = sb.pop_front();
      chk({nm, " q"}, q, last.q);
      chk({nm, " r"}, r, last.r);
      chk({nm, " dz"}, dz, last.dz);
    end
  endtask

  // drive one start pulse; returns at the negedge after the sampling edge
  task automatic launch(input logic [3:0] va,
                        input logic [3:0] vb);
    a     = va;
    b     = vb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // wait for done from cycle cyc0, check latency, busy count and result
  task automatic await(input string nm, input int cyc0,
                       input int lat, input int bexp);
    int cyc;
    int bc;
    cyc = cyc0;
    bc  = cyc0 - 1 + (busy ? 1 : 0);
    while (!done && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (busy) bc++;
    end
    if (!done) begin
      chk({nm, " timeout"}, 0, 1);
    end else begin
      chk({nm, " latency"}, cyc, lat);
      chk({nm, " busy cycles"}, bc, bexp);
      pop_cmp(nm);
    end
  endtask

  task automatic no_done(input string nm, input int n);
    int cnt;
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk({nm, " stray done"}, cnt, 0);
  endtask

  initial begin
    vec_t tbl[9];
    tbl[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0};
    tbl[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
    tbl[2] = '{4'd5,  4'd9,  4'd0,  4'd5, 1'b0};
    tbl[3] = '{4'd7,  4'd0,  4'd15, 4'd7, 1'b1};
    tbl[4] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0};
    tbl[5] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
    tbl[6] = '{4'd8,  4'd3,  4'd2,  4'd2, 1'b0};
    tbl[7] = '{4'd0,  4'd0,  4'd15, 4'd0, 1'b1};
    tbl[8] = '{4'd15, 4'd2,  4'd7,  4'd1, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset q", q, 0);
    chk("reset r", r, 0);
    chk("reset dz", dz, 0);
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      push(tbl[i].q, tbl[i].r, tbl[i].dz);
      launch(tbl[i].a, tbl[i].b);
      await($sformatf("vec%0d", i), 1,
            (tbl[i].b == 0) ? 1 : 5,
            (tbl[i].b == 0) ? 0 : 4);
      @(negedge clk);
      chk($sformatf("vec%0d pulse", i), done, 0);
      chk($sformatf("vec%0d hold q", i), q, last.q);
      chk($sformatf("vec%0d hold r", i), r, last.r);
    end

    for (int i = 0; i < 10; i++) begin
      logic [3:0] ra;
      logic [3:0] rb;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      if (rb == 0) push(4'hf, ra, 1'b1);
      else push(ra / rb, ra % rb, 1'b0);
      launch(ra, rb);
      await($sformatf("rnd %0d/%0d", ra, rb), 1,
            (rb == 0) ? 1 : 5, (rb == 0) ? 0 : 4);
      @(negedge clk);
    end

    push(4'd4, 4'd1, 1'b0);
    launch(4'd13, 4'd3);
    @(negedge clk);
    a     = 4'd2;
    b     = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    await("ignore start", 3, 5, 4);
    no_done("ignore start", 8);

    push(4'd2, 4'd4, 1'b0);
    launch(4'd14, 4'd5);
    await("b2b first", 1, 5, 4);
    push(4'd4, 4'd1, 1'b0);
    a     = 4'd9;
    b     = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    await("b2b second", 1, 5, 4);
    @(negedge clk);

    a     = 4'd13;
    b     = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid reset busy", busy, 0);
    chk("mid reset done", done, 0);
    chk("mid reset q", q, 0);
    chk("mid reset r", r, 0);
    no_done("mid reset", 8);
    push(4'd1, 4'd2, 1'b0);
    launch(4'd6, 4'd4);
    await("after reset", 1, 5, 4);
    @(negedge clk);

    chk("scoreboard empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
